// File: rtl/sram_axi_pkg.sv
// Shared types and constants for the like-SRAM to AXI3 bridge.
// Holds the read and write FSM state types, the fixed AXI field values
// and the SRAM-size to AXI-size mapping.
package sram_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ADDR = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_SEND = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  // SRAM size code (bytes = 2**size) maps directly onto AXI AxSIZE.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_wr_ctrl.sv
// Write channel sequencer: latches one accepted data write, drives AW and W
// (each valid drops on its own handshake), then waits for B.
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   i_accept              data write accepted this cycle (req & addr_ok & wr)
//   i_addr/size/wstrb/wdata  write payload captured on i_accept
//   i_awready/i_wready/i_bvalid  AXI handshake inputs
//   o_idle                write FSM in WR_IDLE
//   o_b_done              B handshake this cycle
//   o_aw*/o_w*/o_bready   AXI AW/W/B master outputs
module sram_axi_wr_ctrl
  import sram_axi_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_accept,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_awready,
  input  logic              i_wready,
  input  logic              i_bvalid,
  output logic              o_idle,
  output logic              o_b_done,
  output logic [ADDR_W-1:0] o_awaddr,
  output logic [2:0]        o_awsize,
  output logic              o_awvalid,
  output logic [DATA_W-1:0] o_wdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic              o_wvalid,
  output logic              o_bready
);

  wr_state_t         r_state;
  wr_state_t         w_next;
  logic              r_awvalid;
  logic              r_wvalid;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              w_start;

  assign w_start = (r_state == WR_IDLE) && i_accept;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= WR_IDLE;
    else         r_state <= w_next;
  end

  // Next state: WR_SEND waits until both registered valids have dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WR_IDLE: if (i_accept) w_next = WR_SEND;
      WR_SEND: if (!r_awvalid && !r_wvalid) w_next = WR_RESP;
      WR_RESP: if (i_bvalid) w_next = WR_IDLE;
      default: w_next = WR_IDLE;
    endcase
  end

  // AW and W valids are independent; each clears on its own ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else if (w_start) begin
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
    end else begin
      if (i_awready) r_awvalid <= 1'b0;
      if (i_wready)  r_wvalid  <= 1'b0;
    end
  end

  // Payload stays stable until the next write so RAW compare can use it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_start) begin
      r_addr  <= i_addr;
      r_size  <= axi_size(i_size);
      r_wdata <= i_wdata;
      r_wstrb <= i_wstrb;
    end
  end

  assign o_idle    = (r_state == WR_IDLE);
  assign o_bready  = (r_state == WR_RESP);
  assign o_b_done  = o_bready && i_bvalid;
  assign o_awaddr  = r_addr;
  assign o_awsize  = r_size;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_wvalid  = r_wvalid;

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the instruction and data like-SRAM ports onto one AXI3 master.
// Reads: one shared AR channel, data beats inst, at most one read per ID,
// R routed back by ID. Writes: handled by sram_axi_wr_ctrl (data port only).
// Ports: clk/resetn (sync active-low); inst_sram_* fetch port;
// data_sram_* load/store port; ar*/r*/aw*/w*/b* AXI3 master channels.
// Build option SRAM_AXI_RAW_CHECK_EN: when defined, only data reads to the
// same word as the pending write are held; otherwise every read is held
// while a write is in flight.
module sram_axi_bridge
  import sram_axi_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_req,
  input  logic [1:0]        inst_sram_size,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  rd_state_t         r_rd_state;
  rd_state_t         w_rd_next;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arsize;
  logic [ID_W-1:0]   r_arid;
  logic              r_rready;
  logic              r_inst_outst;
  logic              r_data_outst;
  logic              r_inst_data_ok;
  logic              r_data_data_ok;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;

  logic w_rd_idle;
  logic w_wr_idle;
  logic w_b_done;
  logic w_hold_inst;
  logic w_hold_data;
  logic w_data_rd_sel;
  logic w_inst_rd_sel;
  logic w_data_wr_acc;
  logic w_r_inst;
  logic w_r_data;
  logic w_unused_ok;

  // Read-after-write protection against the in-flight write.
`ifdef SRAM_AXI_RAW_CHECK_EN
  assign w_hold_inst = 1'b0;
  assign w_hold_data = !w_wr_idle && (data_sram_addr[ADDR_W-1:2] == awaddr[ADDR_W-1:2]);
`else
  assign w_hold_inst = !w_wr_idle;
  assign w_hold_data = !w_wr_idle;
`endif

  // Acceptance: data read wins the AR slot over inst in RD_IDLE.
  assign w_rd_idle     = (r_rd_state == RD_IDLE);
  assign w_data_rd_sel = data_sram_req && !data_sram_wr && w_rd_idle
                         && !r_data_outst && !w_hold_data;
  assign w_inst_rd_sel = inst_sram_req && w_rd_idle && !r_inst_outst
                         && !w_hold_inst && !w_data_rd_sel;
  assign w_data_wr_acc = data_sram_req && data_sram_wr && w_wr_idle && !r_data_outst;

  assign inst_sram_addr_ok = w_inst_rd_sel;
  assign data_sram_addr_ok = w_data_rd_sel || w_data_wr_acc;

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) r_rd_state <= RD_IDLE;
    else         r_rd_state <= w_rd_next;
  end

  // Read FSM next state.
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_data_rd_sel || w_inst_rd_sel) w_rd_next = RD_ADDR;
      RD_ADDR: if (arready) w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  // Latch the selected read for the AR channel.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_araddr <= '0;
      r_arsize <= '0;
      r_arid   <= '0;
    end else if (w_data_rd_sel) begin
      r_araddr <= data_sram_addr;
      r_arsize <= axi_size(data_sram_size);
      r_arid   <= DATA_ID;
    end else if (w_inst_rd_sel) begin
      r_araddr <= inst_sram_addr;
      r_arsize <= axi_size(inst_sram_size);
      r_arid   <= INST_ID;
    end
  end

  assign w_r_inst = rvalid && r_rready && (rid == INST_ID);
  assign w_r_data = rvalid && r_rready && (rid == DATA_ID);

  // One outstanding read per ID: set on acceptance, cleared on its R beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_inst_outst <= 1'b0;
      r_data_outst <= 1'b0;
    end else begin
      if (w_inst_rd_sel)  r_inst_outst <= 1'b1;
      else if (w_r_inst)  r_inst_outst <= 1'b0;
      if (w_data_rd_sel)  r_data_outst <= 1'b1;
      else if (w_r_data)  r_data_outst <= 1'b0;
    end
  end

  // Response return; rready held low only while in reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rready       <= 1'b0;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
      r_inst_rdata   <= '0;
      r_data_rdata   <= '0;
    end else begin
      r_rready       <= 1'b1;
      r_inst_data_ok <= w_r_inst;
      r_data_data_ok <= w_r_data || w_b_done;
      if (w_r_inst) r_inst_rdata <= rdata;
      if (w_r_data) r_data_rdata <= rdata;
    end
  end

  sram_axi_wr_ctrl u_wr_ctrl (
    .clk       (clk),
    .resetn    (resetn),
    .i_accept  (w_data_wr_acc),
    .i_addr    (data_sram_addr),
    .i_size    (data_sram_size),
    .i_wstrb   (data_sram_wstrb),
    .i_wdata   (data_sram_wdata),
    .i_awready (awready),
    .i_wready  (wready),
    .i_bvalid  (bvalid),
    .o_idle    (w_wr_idle),
    .o_b_done  (w_b_done),
    .o_awaddr  (awaddr),
    .o_awsize  (awsize),
    .o_awvalid (awvalid),
    .o_wdata   (wdata),
    .o_wstrb   (wstrb),
    .o_wvalid  (wvalid),
    .o_bready  (bready)
  );

  // Response status and IDs of single-beat transfers carry no extra information here.
  assign w_unused_ok = ^{rresp, rlast, bid, bresp};

  assign inst_sram_data_ok = r_inst_data_ok;
  assign inst_sram_rdata   = r_inst_rdata;
  assign data_sram_data_ok = r_data_data_ok;
  assign data_sram_rdata   = r_data_rdata;

  assign arid    = r_arid;
  assign araddr  = r_araddr;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = r_arsize;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign arvalid = (r_rd_state == RD_ADDR);
  assign rready  = r_rready;

  assign awid    = DATA_ID;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;

endmodule
